// File: rtl/mode_selector_pkg.sv
// mode_selector_pkg: shared constants for the mode selector.
//   DEF_*         default parameter values for mode_selector / key_conditioner
//   KEY_PRESSED   electrical level of a pressed (active-low) push button
//   KEY_RELEASED  electrical level of a released push button
package mode_selector_pkg;

  localparam int unsigned DEF_NUM_MODES       = 4;
  localparam int unsigned DEF_WIDTH           = 10;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_conditioner.sv
// key_conditioner: turns one raw active-low push button into a clean press event.
//   Two-flop synchronizer, optional debounce, then falling-edge (release->press) detection.
//   Optional feature macro: MODE_SELECTOR_DEBOUNCE_EN
//     defined   : conditioned state follows the synchronized key only after it has differed
//                 for DEBOUNCE_CYCLES consecutive cycles (counter clears when they agree).
//     undefined : conditioned state is a registered copy of the synchronized key.
// Ports:
//   CLK    in  clock, rising edge
//   RST    in  synchronous active-high reset (everything returns to "released")
//   KEY_N  in  asynchronous active-low key
//   PRESS  out single-cycle pulse on each accepted press
module key_conditioner
  import mode_selector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY_N,
  output logic PRESS
);

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("key_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1_q, sync2_q;
  logic cond_q, cond_prev_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= KEY_RELEASED;
      sync2_q <= KEY_RELEASED;
    end else begin
      sync1_q <= KEY_N;
      sync2_q <= sync1_q;
    end
  end

`ifdef MODE_SELECTOR_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cond_d;

  always_comb begin
    cnt_d  = '0;
    cond_d = cond_q;
    if (sync2_q != cond_q) begin
      // The D-th consecutive disagreeing cycle commits the new level.
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        cond_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      cond_q <= KEY_RELEASED;
    end else begin
      cnt_q  <= cnt_d;
      cond_q <= cond_d;
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      cond_q <= KEY_RELEASED;
    end else begin
      cond_q <= sync2_q;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      cond_prev_q <= KEY_RELEASED;
    end else begin
      cond_prev_q <= cond_q;
    end
  end

  // Both registers reset to released, so a key held through reset still yields one press.
  assign PRESS = (cond_q == KEY_PRESSED) && (cond_prev_q != KEY_PRESSED);

endmodule

// File: rtl/mode_selector.sv
// mode_selector: two push buttons step a mode index that selects one of NUM_MODES channels.
//   Optional feature macro: MODE_SELECTOR_DEBOUNCE_EN (key debounce inside key_conditioner).
// Parameters:
//   NUM_MODES        number of channels, 2..16
//   WIDTH            bits per channel
//   DEBOUNCE_CYCLES  stable cycles before a key level is accepted (debounce builds)
// Ports:
//   CLK           in  clock, rising edge
//   RST           in  synchronous active-high reset
//   KEY_NEXT      in  async active-low key, steps mode up (wraps to 0)
//   KEY_PREV      in  async active-low key, steps mode down (wraps to NUM_MODES-1)
//   CH_IN         in  packed channels, channel k at [k*WIDTH +: WIDTH]
//   MODE          out current mode index
//   DATA_OUT      out registered copy of channel[MODE]
//   MODE_CHANGED  out one-cycle pulse coincident with a new MODE value
module mode_selector
  import mode_selector_pkg::*;
#(
  parameter int unsigned NUM_MODES       = DEF_NUM_MODES,
  parameter int unsigned WIDTH           = DEF_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  localparam int unsigned MODE_W         = $clog2(NUM_MODES)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       KEY_NEXT,
  input  logic                       KEY_PREV,
  input  logic [NUM_MODES*WIDTH-1:0] CH_IN,
  output logic [MODE_W-1:0]          MODE,
  output logic [WIDTH-1:0]           DATA_OUT,
  output logic                       MODE_CHANGED
);

  if (NUM_MODES < 2 || NUM_MODES > 16) begin : g_cfg_check
    $error("mode_selector: NUM_MODES must be in 2..16");
  end

  localparam logic [MODE_W-1:0] ModeMax = MODE_W'(NUM_MODES - 1);

  logic next_press, prev_press;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_next (
    .CLK  (CLK),
    .RST  (RST),
    .KEY_N(KEY_NEXT),
    .PRESS(next_press)
  );

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_prev (
    .CLK  (CLK),
    .RST  (RST),
    .KEY_N(KEY_PREV),
    .PRESS(prev_press)
  );

  logic [MODE_W-1:0] mode_q, mode_d;
  logic              changed_q, changed_d;
  logic [WIDTH-1:0]  data_q;

  // Explicit wrap compares keep MODE below NUM_MODES for non-power-of-two counts.
  // Simultaneous NEXT and PREV events cancel.
  always_comb begin
    mode_d    = mode_q;
    changed_d = 1'b0;
    if (next_press && !prev_press) begin
      mode_d    = (mode_q == ModeMax) ? '0 : mode_q + 1'b1;
      changed_d = 1'b1;
    end else if (prev_press && !next_press) begin
      mode_d    = (mode_q == '0) ? ModeMax : mode_q - 1'b1;
      changed_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q    <= '0;
      changed_q <= 1'b0;
      data_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      changed_q <= changed_d;
      data_q    <= CH_IN[mode_q*WIDTH +: WIDTH];
    end
  end

  assign MODE         = mode_q;
  assign MODE_CHANGED = changed_q;
  assign DATA_OUT     = data_q;

endmodule

// File: tb/tb_mode_selector.sv
// tb_mode_selector: scoreboard bench driving a 4-mode/10-bit and a 5-mode/8-bit selector
// from the same keys. Stimulus pushes expected mode updates (cycle + value); a negedge
// monitor checks MODE, MODE_CHANGED and DATA_OUT every cycle.
// Works with or without MODE_SELECTOR_DEBOUNCE_EN.
module tb_mode_selector;

  localparam int D = 16;
`ifdef MODE_SELECTOR_DEBOUNCE_EN
  localparam int DEff = D;      // shortest low/high run that is accepted
  localparam int Lat  = 3 + D;  // key edge to MODE update
`else
  localparam int DEff = 1;
  localparam int Lat  = 4;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, key_next, key_prev;
  logic [39:0] ch4, ch5;
  logic [1:0]  mode4;
  logic [2:0]  mode5;
  logic [9:0]  data4;
  logic [7:0]  data5;
  logic        chg4, chg5;

  mode_selector u_dut4 (
    .CLK         (clk),
    .RST         (rst),
    .KEY_NEXT    (key_next),
    .KEY_PREV    (key_prev),
    .CH_IN       (ch4),
    .MODE        (mode4),
    .DATA_OUT    (data4),
    .MODE_CHANGED(chg4)
  );

  mode_selector #(
    .NUM_MODES(5),
    .WIDTH    (8)
  ) u_dut5 (
    .CLK         (clk),
    .RST         (rst),
    .KEY_NEXT    (key_next),
    .KEY_PREV    (key_prev),
    .CH_IN       (ch5),
    .MODE        (mode5),
    .DATA_OUT    (data5),
    .MODE_CHANGED(chg5)
  );

  typedef struct {
    int due;
    int m4;
    int m5;
  } ev_t;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  exp_m4  = 0;
  int  exp_m5  = 0;
  bit  ch_rand = 1'b1;
  logic [39:0] ch4_fix = '0;

  always @(posedge clk) cyc = cyc + 1;

  // Channel data: random every cycle unless a fixed pattern is requested for ch4.
  initial begin
    logic [63:0] r;
    ch4 = '0;
    ch5 = '0;
    forever begin
      @(posedge clk);
      #1;
      r   = {$urandom(), $urandom()};
      ch5 = r[63:24];
      ch4 = ch_rand ? r[39:0] : ch4_fix;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int chan4(input logic [39:0] v, input int m);
    logic [9:0] r;
    r = v[m*10 +: 10];
    return int'(r);
  endfunction

  function automatic int chan5(input logic [39:0] v, input int m);
    logic [7:0] r;
    r = v[m*8 +: 8];
    return int'(r);
  endfunction

  // Monitor
  logic        prev_rst = 1'b1;
  logic [39:0] prev_ch4 = '0, prev_ch5 = '0;
  int          prev_m4 = 0, prev_m5 = 0;
  int          mm4 = 0, mm5 = 0;
  bit          mon_init = 1'b0;
  ev_t         ev;
  int          e_chg, e_d4, e_d5;

  always @(negedge clk) begin
    if (mon_init) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("missed_event", 0, 1);
        void'(sb.pop_front());
      end
      e_chg = 0;
      if (prev_rst) begin
        mm4  = 0;
        mm5  = 0;
        e_d4 = 0;
        e_d5 = 0;
      end else begin
        e_d4 = chan4(prev_ch4, prev_m4);
        e_d5 = chan5(prev_ch5, prev_m5);
        if (sb.size() > 0 && sb[0].due == cyc) begin
          ev    = sb.pop_front();
          mm4   = ev.m4;
          mm5   = ev.m5;
          e_chg = 1;
        end
      end
      check("mode4", int'(mode4), mm4);
      check("mode5", int'(mode5), mm5);
      check("changed4", int'(chg4), e_chg);
      check("changed5", int'(chg5), e_chg);
      check("data4", int'(data4), e_d4);
      check("data5", int'(data5), e_d5);
      check("mode5_range", int'(mode5 < 3'd5), 1);
    end
    mon_init = 1'b1;
    prev_rst = rst;
    prev_ch4 = ch4;
    prev_ch5 = ch5;
    prev_m4  = mm4;
    prev_m5  = mm5;
  end

  // Stimulus
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_event(input bit nxt, input bit prv, input int due);
    if (nxt && !prv) begin
      exp_m4 = (exp_m4 + 1) % 4;
      exp_m5 = (exp_m5 + 1) % 5;
    end else if (prv && !nxt) begin
      exp_m4 = (exp_m4 + 3) % 4;
      exp_m5 = (exp_m5 + 4) % 5;
    end else begin
      return;
    end
    sb.push_back(ev_t'{due, exp_m4, exp_m5});
  endtask

  // A low run of at least DEff cycles is one accepted press.
  task automatic press(input bit nxt, input bit prv, input int hold, input int gap);
    int c;
    c        = cyc;
    key_next = nxt ? 1'b0 : 1'b1;
    key_prev = prv ? 1'b0 : 1'b1;
    if (hold >= DEff) push_event(nxt, prv, c + Lat);
    step(hold);
    key_next = 1'b1;
    key_prev = 1'b1;
    step(gap);
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    exp_m4 = 0;
    exp_m5 = 0;
    step(n);
    rst = 1'b0;
  endtask

  initial begin
    int op, hold, gap;
    rst      = 1'b1;
    key_next = 1'b1;
    key_prev = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);

    // Seven clean NEXT presses: dut4 1,2,3,0,1,2,3; dut5 1,2,3,4,0,1,2.
    repeat (7) press(1'b1, 1'b0, DEff + 4, DEff + 6);

    // From mode 0 one PREV press -> mode 3, channel 3 fixed at 10'h2A5.
    do_reset(2);
    step(2);
    ch_rand = 1'b0;
    ch4_fix = {10'h2A5, 10'h0F0, 10'h00F, 10'h3C3};
    step(1);
    press(1'b0, 1'b1, DEff + 4, DEff + 10);
    ch_rand = 1'b1;

    // Bouncing NEXT (15-cycle pulses), then a solid 40-cycle hold.
    repeat (4) press(1'b1, 1'b0, 15, 15);
    press(1'b1, 1'b0, 40, DEff + 6);

    // Simultaneous NEXT and PREV cancel.
    repeat (2) press(1'b1, 1'b1, DEff + 4, DEff + 6);

    // Random presses, hold lengths straddling the acceptance threshold.
    for (int i = 0; i < 24; i++) begin
      op   = $urandom_range(0, 3);
      hold = $urandom_range((DEff > 3) ? DEff - 3 : 1, DEff + 6);
      gap  = $urandom_range(DEff + 2, DEff + 8);
      case (op)
        0, 1:    press(1'b1, 1'b0, hold, gap);
        2:       press(1'b0, 1'b1, hold, gap);
        default: press(1'b1, 1'b1, hold, gap);
      endcase
    end

    // Reset while a press is half debounced, key released during reset: no event.
`ifdef MODE_SELECTOR_DEBOUNCE_EN
    hold = 2 + D / 2;
`else
    hold = 2;
`endif
    key_next = 1'b0;
    step(hold);
    rst    = 1'b1;
    exp_m4 = 0;
    exp_m5 = 0;
    step(3);
    key_next = 1'b1;
    step(1);
    rst = 1'b0;
    step(DEff + 10);

    // Key held through reset release: exactly one event after re-debounce.
    key_next = 1'b0;
    do_reset(3);
    push_event(1'b1, 1'b0, cyc + Lat);
    step(DEff + 6);
    key_next = 1'b1;
    step(DEff + 6);

    step(Lat + 5);
    check("queue_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
